// File: rtl/user_obi_mgr_arbiter_if.sv
// Bundle of the shared-port signals: requester-side bus and the single OBI manager port.
// The master modport is the arbiter's view; slave is the view of whoever drives the requesters and memory.
interface user_obi_mgr_arbiter_if #(
  parameter int NumReq    = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  localparam int BeWidth = DataWidth / 8;

  logic [NumReq-1:0]           req_i;
  logic [NumReq-1:0]           we_i;
  logic [NumReq*AddrWidth-1:0] addr_i;
  logic [NumReq*DataWidth-1:0] wdata_i;
  logic [NumReq*BeWidth-1:0]   be_i;
  logic [NumReq-1:0]           gnt_o;
  logic [NumReq-1:0]           rvalid_o;
  logic [DataWidth-1:0]        rdata_o;
  logic                        err_o;

  logic                        mgr_req_o;
  logic                        mgr_we_o;
  logic [AddrWidth-1:0]        mgr_addr_o;
  logic [DataWidth-1:0]        mgr_wdata_o;
  logic [BeWidth-1:0]          mgr_be_o;
  logic                        mgr_gnt_i;
  logic                        mgr_rvalid_i;
  logic [DataWidth-1:0]        mgr_rdata_i;
  logic                        mgr_err_i;

  modport master (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output mgr_req_o, mgr_we_o, mgr_addr_o, mgr_wdata_o, mgr_be_o,
    input  mgr_gnt_i, mgr_rvalid_i, mgr_rdata_i, mgr_err_i
  );

  modport slave (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  mgr_req_o, mgr_we_o, mgr_addr_o, mgr_wdata_o, mgr_be_o,
    output mgr_gnt_i, mgr_rvalid_i, mgr_rdata_i, mgr_err_i
  );
endinterface

// File: rtl/user_obi_mgr_arbiter.sv
// Round-robin arbiter sharing one OBI manager port among NumReq requesters, with an
// in-order FIFO of granted requester indices used to route responses back.
module user_obi_mgr_arbiter #(
  parameter int NumReq    = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int MaxTrans  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  user_obi_mgr_arbiter_if.master        bus,
  output logic [$clog2(MaxTrans+1)-1:0] outstanding_o,
  output logic                          stray_rsp_o,
  output logic                          dbg_lock_o
);
  // Handshake rule: an address phase completes in the cycle where mgr_req_o and mgr_gnt_i
  // are both 1; once mgr_req_o is raised the chosen requester and its payload are held
  // until that handshake. Each mgr_rvalid_i answers the oldest un-answered grant.

  localparam int BeWidth = DataWidth / 8;
  localparam int IdxW    = $clog2(NumReq);
  localparam int PtrW    = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int CntW    = $clog2(MaxTrans + 1);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t            r_state, w_state_nxt;
  logic [IdxW-1:0]   r_lock_sel, w_lock_sel_nxt;
  logic [IdxW-1:0]   r_ptr;
  logic [IdxW-1:0]   r_fifo [MaxTrans];
  logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              r_stray;

  logic [IdxW-1:0]   w_rr_sel, w_sel, w_idx, w_head;
  logic              w_found, w_mgr_req, w_hs, w_pop;

  // Round-robin scan starting at the priority pointer.
  always_comb begin
    w_rr_sel = r_ptr;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < NumReq; k++) begin
      w_idx = IdxW'((int'(r_ptr) + k) % NumReq);
      if (!w_found && bus.req_i[w_idx]) begin
        w_found  = 1'b1;
        w_rr_sel = w_idx;
      end
    end
  end

  assign w_sel     = (r_state == ST_LOCK) ? r_lock_sel : w_rr_sel;
  assign w_head    = r_fifo[r_rd_ptr];
  assign w_mgr_req = !rst_i && bus.req_i[w_sel] && (r_count < CntW'(MaxTrans));
  assign w_hs      = w_mgr_req && bus.mgr_gnt_i;
  assign w_pop     = !rst_i && bus.mgr_rvalid_i && (r_count != '0);

  always_comb begin
    bus.gnt_o    = '0;
    bus.rvalid_o = '0;
    if (w_hs)  bus.gnt_o[w_sel]     = 1'b1;
    if (w_pop) bus.rvalid_o[w_head] = 1'b1;
  end

  assign bus.rdata_o     = bus.mgr_rdata_i;
  assign bus.err_o       = bus.mgr_err_i;
  assign bus.mgr_req_o   = w_mgr_req;
  assign bus.mgr_we_o    = w_mgr_req && bus.we_i[w_sel];
  assign bus.mgr_addr_o  = w_mgr_req ? bus.addr_i[w_sel*AddrWidth +: AddrWidth] : '0;
  assign bus.mgr_wdata_o = w_mgr_req ? bus.wdata_i[w_sel*DataWidth +: DataWidth] : '0;
  assign bus.mgr_be_o    = w_mgr_req ? bus.be_i[w_sel*BeWidth +: BeWidth] : '0;

  assign outstanding_o = r_count;
  assign stray_rsp_o   = r_stray;
  assign dbg_lock_o    = (r_state == ST_LOCK);

  // Lock FSM: a stalled request pins the selection until its grant arrives.
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_sel_nxt = r_lock_sel;
    case (r_state)
      ST_IDLE: begin
        if (w_mgr_req && !bus.mgr_gnt_i) begin
          w_state_nxt    = ST_LOCK;
          w_lock_sel_nxt = w_rr_sel;
        end
      end
      ST_LOCK: begin
        if (w_hs) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_lock_sel <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_sel <= w_lock_sel_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_stray  <= 1'b0;
      for (int i = 0; i < MaxTrans; i++) r_fifo[i] <= '0;
    end else begin
      if (w_hs) begin
        r_fifo[r_wr_ptr] <= w_sel;
        r_wr_ptr <= (r_wr_ptr == PtrW'(MaxTrans - 1)) ? '0 : r_wr_ptr + 1'b1;
        r_ptr    <= (w_sel == IdxW'(NumReq - 1)) ? '0 : w_sel + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PtrW'(MaxTrans - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A response with nothing outstanding has no owner; flag it and drop it.
      if (bus.mgr_rvalid_i && (r_count == '0)) r_stray <= 1'b1;
    end
  end
endmodule

// File: tb/tb_user_obi_mgr_arbiter.sv
// Directed bench for user_obi_mgr_arbiter: 2 requesters, MaxTrans=2, hand-computed expectations.
module tb_user_obi_mgr_arbiter;
  localparam int NumReq    = 2;
  localparam int AddrWidth = 32;
  localparam int DataWidth = 32;
  localparam int MaxTrans  = 2;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [1:0] outstanding_o;
  logic       stray_rsp_o;
  logic       dbg_lock_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] exp_q[$];
  logic [1:0] gnt_tab[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0] exp_rv;

  user_obi_mgr_arbiter_if #(.NumReq(NumReq), .AddrWidth(AddrWidth), .DataWidth(DataWidth)) bus ();

  user_obi_mgr_arbiter #(
    .NumReq(NumReq), .AddrWidth(AddrWidth), .DataWidth(DataWidth), .MaxTrans(MaxTrans)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .bus           (bus.master),
    .outstanding_o (outstanding_o),
    .stray_rsp_o   (stray_rsp_o),
    .dbg_lock_o    (dbg_lock_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drivers: inputs change on the falling edge, outputs checked 1ns later.
  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rdata);
    @(negedge clk_i);
    bus.req_i        = req;
    bus.mgr_gnt_i    = gnt;
    bus.mgr_rvalid_i = rv;
    bus.mgr_rdata_i  = rdata;
    #1;
  endtask

  task automatic set_payload(input logic [31:0] a0, input logic [31:0] a1);
    bus.addr_i  = {a1, a0};
    bus.we_i    = 2'b10;
    bus.wdata_i = {32'hDEADBEEF, 32'h11111111};
    bus.be_i    = {4'hF, 4'h3};
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i            = 1'b1;
    bus.req_i        = '0;
    bus.mgr_gnt_i    = 1'b0;
    bus.mgr_rvalid_i = 1'b0;
    bus.mgr_rdata_i  = '0;
    bus.mgr_err_i    = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    bus.req_i = '0; bus.mgr_gnt_i = 1'b0; bus.mgr_rvalid_i = 1'b0;
    bus.mgr_rdata_i = '0; bus.mgr_err_i = 1'b0;
    set_payload(32'h100, 32'h300);
    #1;
    check("rst_gnt", bus.gnt_o, 2'b00);
    check("rst_rvalid", bus.rvalid_o, 2'b00);
    check("rst_mgr_req", bus.mgr_req_o, 1'b0);
    check("rst_outstanding", outstanding_o, 2'd0);
    check("rst_stray", stray_rsp_o, 1'b0);
    do_reset();

    // 1: single read from requester 0
    drive(2'b01, 1'b1, 1'b0, '0);
    check("t1_gnt", bus.gnt_o, 2'b01);
    check("t1_addr", bus.mgr_addr_o, 32'h100);
    check("t1_we", bus.mgr_we_o, 1'b0);
    drive(2'b00, 1'b0, 1'b1, 32'hA5A5A5A5);
    check("t1_rvalid", bus.rvalid_o, 2'b01);
    check("t1_rdata", bus.rdata_o, 32'hA5A5A5A5);
    check("t1_outstanding_pre", outstanding_o, 2'd1);
    drive(2'b00, 1'b0, 1'b0, '0);
    check("t1_outstanding_post", outstanding_o, 2'd0);

    // 2: both requesting, grant every cycle; scoreboard tracks response routing
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, (i > 0), 32'hC0DE0000 + 32'(i));
      check("t2_gnt", bus.gnt_o, gnt_tab[i]);
      if (i == 1) begin
        check("t2_wr_we", bus.mgr_we_o, 1'b1);
        check("t2_wr_wdata", bus.mgr_wdata_o, 32'hDEADBEEF);
        check("t2_wr_be", bus.mgr_be_o, 4'hF);
        check("t2_wr_addr", bus.mgr_addr_o, 32'h300);
      end
      if (i > 0) begin
        exp_rv = exp_q.pop_front();
        check("t2_rvalid", bus.rvalid_o, exp_rv);
        check("t2_outstanding", outstanding_o, 2'd1);
      end
      exp_q.push_back(gnt_tab[i]);
    end
    drive(2'b00, 1'b0, 1'b1, 32'hC0DE0004);
    exp_rv = exp_q.pop_front();
    check("t2_rvalid_last", bus.rvalid_o, exp_rv);
    check("t2_rdata_last", bus.rdata_o, 32'hC0DE0004);

    // 3: stalled request locks selection against a new requester
    do_reset();
    set_payload(32'h200, 32'h300);
    drive(2'b01, 1'b0, 1'b0, '0);
    check("t3_c1_gnt", bus.gnt_o, 2'b00);
    check("t3_c1_addr", bus.mgr_addr_o, 32'h200);
    check("t3_c1_lock", dbg_lock_o, 1'b0);
    drive(2'b11, 1'b0, 1'b0, '0);
    check("t3_c2_addr", bus.mgr_addr_o, 32'h200);
    check("t3_c2_lock", dbg_lock_o, 1'b1);
    drive(2'b11, 1'b0, 1'b0, '0);
    check("t3_c3_addr", bus.mgr_addr_o, 32'h200);
    drive(2'b11, 1'b1, 1'b0, '0);
    check("t3_c4_gnt", bus.gnt_o, 2'b01);
    check("t3_c4_addr", bus.mgr_addr_o, 32'h200);
    drive(2'b10, 1'b1, 1'b0, '0);
    check("t3_c5_gnt", bus.gnt_o, 2'b10);
    check("t3_c5_addr", bus.mgr_addr_o, 32'h300);
    check("t3_c5_lock", dbg_lock_o, 1'b0);
    drive(2'b00, 1'b0, 1'b1, 32'h1);
    check("t3_rv0", bus.rvalid_o, 2'b01);
    drive(2'b00, 1'b0, 1'b1, 32'h2);
    check("t3_rv1", bus.rvalid_o, 2'b10);

    // 4: FIFO full blocks issue, even with a same-cycle pop
    do_reset();
    set_payload(32'h100, 32'h300);
    drive(2'b01, 1'b1, 1'b0, '0);
    check("t4_g1", bus.gnt_o, 2'b01);
    drive(2'b01, 1'b1, 1'b0, '0);
    check("t4_g2", bus.gnt_o, 2'b01);
    drive(2'b01, 1'b1, 1'b0, '0);
    check("t4_full_req", bus.mgr_req_o, 1'b0);
    check("t4_full_gnt", bus.gnt_o, 2'b00);
    check("t4_full_cnt", outstanding_o, 2'd2);
    drive(2'b01, 1'b1, 1'b1, 32'h5);
    check("t4_pop_req", bus.mgr_req_o, 1'b0);
    check("t4_pop_rvalid", bus.rvalid_o, 2'b01);
    drive(2'b01, 1'b1, 1'b0, '0);
    check("t4_after_cnt", outstanding_o, 2'd1);
    check("t4_after_req", bus.mgr_req_o, 1'b1);
    check("t4_after_gnt", bus.gnt_o, 2'b01);
    drive(2'b00, 1'b0, 1'b1, '0);
    drive(2'b00, 1'b0, 1'b1, '0);
    drive(2'b00, 1'b0, 1'b0, '0);
    check("t4_drained", outstanding_o, 2'd0);
    check("t4_no_stray", stray_rsp_o, 1'b0);

    // 5: response with nothing outstanding
    do_reset();
    drive(2'b00, 1'b0, 1'b1, 32'hBAD);
    check("t5_rvalid", bus.rvalid_o, 2'b00);
    check("t5_stray_pre", stray_rsp_o, 1'b0);
    drive(2'b00, 1'b0, 1'b0, '0);
    check("t5_stray", stray_rsp_o, 1'b1);

    // 6: reset with a transaction in flight
    do_reset();
    check("t6_stray_clr", stray_rsp_o, 1'b0);
    drive(2'b10, 1'b1, 1'b0, '0);
    check("t6_gnt", bus.gnt_o, 2'b10);
    @(negedge clk_i);
    rst_i = 1'b1; bus.req_i = 2'b11; bus.mgr_gnt_i = 1'b1; bus.mgr_rvalid_i = 1'b1;
    #1;
    check("t6_rst_gnt", bus.gnt_o, 2'b00);
    check("t6_rst_rvalid", bus.rvalid_o, 2'b00);
    check("t6_rst_mgr_req", bus.mgr_req_o, 1'b0);
    check("t6_rst_outstanding", outstanding_o, 2'd0);
    check("t6_rst_stray", stray_rsp_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0; bus.req_i = '0; bus.mgr_gnt_i = 1'b0; bus.mgr_rvalid_i = 1'b0;
    drive(2'b00, 1'b0, 1'b1, 32'h7);
    check("t6_late_rvalid", bus.rvalid_o, 2'b00);
    drive(2'b11, 1'b1, 1'b0, '0);
    check("t6_stray", stray_rsp_o, 1'b1);
    check("t6_ptr_zero", bus.gnt_o, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
